// File: rtl/lcd_cfah_responder.sv
// ----------------------------------------------------------------------------
// lcd_cfah_responder
//   Device-side model of the CFAH1602 parallel bus. It sits where the LCD
//   controller would be and answers the initiator (lcd_cfah_itf). It samples
//   RS/RW/EN/DATA, captures writes, drives read data, and models the busy flag
//   and the 7-bit DDRAM address counter.
//
// Configuration macro: LCD_RESP_BUSY_EN
//   defined   : busy counter, o_busy, status busy bit and o_violation active
//   undefined : no busy counter; o_busy, status bit7 and o_violation are 0
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   i_rs/i_rw      RS (0 instr/status, 1 data), RW (0 write, 1 read)
//   i_en           EN strobe, asynchronous to clk
//   i_data         bus data from the initiator
//   o_data         read data, valid while o_data_oe=1
//   o_data_oe      tristate enable for o_data
//   i_rd_data      byte returned on data reads
//   o_wr_data      captured write byte, o_wr_rs its RS
//   o_wr_val       1-cycle pulse: write completed
//   o_rd_val       1-cycle pulse: read completed
//   o_busy         busy flag
//   o_addr         DDRAM address counter
//   o_violation    1-cycle pulse: write or data read completed while busy
// ----------------------------------------------------------------------------
module lcd_cfah_responder #(
  parameter int G_BUSY_CYCLES      = 37,
  parameter int G_BUSY_LONG_CYCLES = 1520,
  parameter int G_CNT_WIDTH        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rs,
  input  logic       i_rw,
  input  logic       i_en,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       o_data_oe,
  input  logic [7:0] i_rd_data,
  output logic [7:0] o_wr_data,
  output logic       o_wr_rs,
  output logic       o_wr_val,
  output logic       o_rd_val,
  output logic       o_busy,
  output logic [6:0] o_addr,
  output logic       o_violation
);

  // Elaboration-time guard: the counter must be able to hold the long delay.
  if ((G_BUSY_LONG_CYCLES >= (2 ** G_CNT_WIDTH)) || (G_BUSY_CYCLES < 1)) begin : g_bad_cfg
    $error("lcd_cfah_responder: busy cycle counts do not fit G_CNT_WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       en_meta_q, en_s_q, en_prev_q;
  logic       en_rise, en_fall;
  logic       rs_q, rs_d;
  logic [7:0] wbuf_q, wbuf_d;
  logic [7:0] rd_hold_q, rd_hold_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       wr_rs_q, wr_rs_d;
  logic       wr_val_q, wr_val_d;
  logic       rd_val_q, rd_val_d;
  logic       viol_q, viol_d;
  logic       busy;
  logic       busy_at_fall;
  logic       is_home;

  assign en_rise = en_s_q & ~en_prev_q;
  assign en_fall = ~en_s_q & en_prev_q;

  // Clear (0x01) and return-home (0x02/0x03) share the long delay.
  assign is_home = (wbuf_q[7:2] == 6'd0) && (wbuf_q[1:0] != 2'd0);

`ifdef LCD_RESP_BUSY_EN
  logic [G_CNT_WIDTH-1:0] busy_cnt_q, busy_cnt_d;
  logic                   busy_load;

  // Only an accepted instruction write reloads the counter.
  assign busy_load = (state_q == S_WR) && en_fall && !rs_q && !busy_at_fall;

  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (busy_load) begin
      busy_cnt_d = is_home ? G_CNT_WIDTH'(G_BUSY_LONG_CYCLES) : G_CNT_WIDTH'(G_BUSY_CYCLES);
    end else if (busy_cnt_q != '0) begin
      busy_cnt_d = busy_cnt_q - G_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_cnt_q <= '0;
    else        busy_cnt_q <= busy_cnt_d;
  end

  assign busy = (busy_cnt_q != '0);
  // A counter at 1 reaches 0 on this edge, so a completing access sees it clear.
  assign busy_at_fall = (busy_cnt_q > G_CNT_WIDTH'(1));
`else
  assign busy         = 1'b0;
  assign busy_at_fall = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rs_d      = rs_q;
    wbuf_d    = wbuf_q;
    rd_hold_d = rd_hold_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    wr_rs_d   = wr_rs_q;
    wr_val_d  = 1'b0;
    rd_val_d  = 1'b0;
    viol_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en_rise) begin
          rs_d = i_rs;
          if (i_rw) begin
            state_d   = S_RD;
            rd_hold_d = i_rd_data;
          end else begin
            state_d = S_WR;
            // Load now too, so a one-cycle EN still captures a byte.
            wbuf_d  = i_data;
          end
        end
      end
      S_WR: begin
        if (en_fall) begin
          state_d   = S_IDLE;
          wr_val_d  = 1'b1;
          wr_data_d = wbuf_q;
          wr_rs_d   = rs_q;
          viol_d    = busy_at_fall;
          if (!busy_at_fall) begin
            if (rs_q)             addr_d = addr_q + 7'd1;
            else if (is_home)     addr_d = 7'd0;
            else if (wbuf_q[7])   addr_d = wbuf_q[6:0];
          end
        end else if (en_s_q) begin
          wbuf_d = i_data;
        end
      end
      S_RD: begin
        if (en_fall) begin
          state_d  = S_IDLE;
          rd_val_d = 1'b1;
          if (rs_q) begin
            addr_d = addr_q + 7'd1;
            viol_d = busy_at_fall;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      en_meta_q <= 1'b0;
      en_s_q    <= 1'b0;
      en_prev_q <= 1'b0;
      rs_q      <= 1'b0;
      wbuf_q    <= 8'h00;
      rd_hold_q <= 8'h00;
      addr_q    <= 7'd0;
      wr_data_q <= 8'h00;
      wr_rs_q   <= 1'b0;
      wr_val_q  <= 1'b0;
      rd_val_q  <= 1'b0;
      viol_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_meta_q <= i_en;
      en_s_q    <= en_meta_q;
      en_prev_q <= en_s_q;
      rs_q      <= rs_d;
      wbuf_q    <= wbuf_d;
      rd_hold_q <= rd_hold_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      wr_rs_q   <= wr_rs_d;
      wr_val_q  <= wr_val_d;
      rd_val_q  <= rd_val_d;
      viol_q    <= viol_d;
    end
  end

  // Output enable comes straight from the state register so reset drops it at once.
  assign o_data_oe   = (state_q == S_RD);
  assign o_data      = o_data_oe ? (rs_q ? rd_hold_q : {busy, addr_q}) : 8'h00;
  assign o_wr_data   = wr_data_q;
  assign o_wr_rs     = wr_rs_q;
  assign o_wr_val    = wr_val_q;
  assign o_rd_val    = rd_val_q;
  assign o_busy      = busy;
  assign o_addr      = addr_q;
  assign o_violation = viol_q;

endmodule

// File: tb/tb_lcd_cfah_responder.sv
module tb_lcd_cfah_responder;

`ifdef LCD_RESP_BUSY_EN
  localparam bit BUSY_EN = 1'b1;
`else
  localparam bit BUSY_EN = 1'b0;
`endif
  localparam int NS = 37;
  localparam int NL = 1520;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_rs = 1'b0, i_rw = 1'b0, i_en = 1'b0;
  logic [7:0] i_data = 8'h00, i_rd_data = 8'h00;
  logic [7:0] o_data, o_wr_data;
  logic       o_data_oe, o_wr_rs, o_wr_val, o_rd_val, o_busy, o_violation;
  logic [6:0] o_addr;

  lcd_cfah_responder #(
    .G_BUSY_CYCLES(NS), .G_BUSY_LONG_CYCLES(NL), .G_CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_rs(i_rs), .i_rw(i_rw), .i_en(i_en),
    .i_data(i_data), .o_data(o_data), .o_data_oe(o_data_oe),
    .i_rd_data(i_rd_data), .o_wr_data(o_wr_data), .o_wr_rs(o_wr_rs),
    .o_wr_val(o_wr_val), .o_rd_val(o_rd_val), .o_busy(o_busy),
    .o_addr(o_addr), .o_violation(o_violation)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  // Reference model: address counter and the cycle at which busy expires.
  logic [6:0] m_addr = 7'd0;
  int         busy_end = 0;

  // Observations of the most recent access.
  int         n_wr, n_rd, n_viol, pulse_cyc;
  logic [7:0] got_wdata, got_rdata;
  logic       got_wrs;
  bit         oe_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    if (o_data_oe) begin oe_seen = 1'b1; got_rdata = o_data; end
    if (o_wr_val) begin n_wr++; got_wdata = o_wr_data; got_wrs = o_wr_rs; pulse_cyc = cyc; end
    if (o_rd_val) n_rd++;
    if (o_violation) n_viol++;
  endtask

  // One bus access, checked against the model. Waits first until the busy
  // state at completion is unambiguous.
  task automatic do_op(input string tag, input logic rs, input logic rw,
                       input logic [7:0] d, input int en_cyc, input bit toggle);
    bit         busy_exp;
    bit         exp_viol;
    logic [7:0] exp_rd;
    if (BUSY_EN)
      while (!(cyc > busy_end + 10) && !(cyc + en_cyc + 14 < busy_end)) @(negedge clk);
    busy_exp = BUSY_EN && (cyc + en_cyc + 14 < busy_end);
    exp_rd   = rs ? i_rd_data : {busy_exp, m_addr};
    n_wr = 0; n_rd = 0; n_viol = 0; pulse_cyc = cyc;
    got_wdata = 8'h00; got_rdata = 8'h00; got_wrs = 1'b0; oe_seen = 1'b0;

    @(negedge clk);
    i_rs = rs; i_rw = rw; i_data = d;
    @(negedge clk);
    i_en = 1'b1;
    for (int k = 0; k < en_cyc; k++) begin
      @(negedge clk);
      if (toggle && k == en_cyc / 2) begin i_rs = ~rs; i_rw = ~rw; end
      sample();
    end
    i_en = 1'b0;
    repeat (8) begin @(negedge clk); sample(); end

    exp_viol = 1'b0;
    if (!rw) begin
      check({tag, "_wr_val"}, n_wr, 1);
      check({tag, "_rd_val"}, n_rd, 0);
      check({tag, "_wr_data"}, got_wdata, d);
      check({tag, "_wr_rs"}, got_wrs, rs);
      if (busy_exp) exp_viol = 1'b1;
      else if (rs) m_addr = m_addr + 7'd1;
      else if (d == 8'h01 || d == 8'h02 || d == 8'h03) begin
        m_addr = 7'd0; busy_end = pulse_cyc + NL;
      end else begin
        if (d[7]) m_addr = d[6:0];
        busy_end = pulse_cyc + NS;
      end
    end else begin
      check({tag, "_rd_val"}, n_rd, 1);
      check({tag, "_wr_val"}, n_wr, 0);
      check({tag, "_oe_seen"}, oe_seen, 1);
      check({tag, "_rd_data"}, got_rdata, exp_rd);
      if (rs) begin exp_viol = busy_exp; m_addr = m_addr + 7'd1; end
    end
    check({tag, "_viol"}, n_viol, exp_viol);
    check({tag, "_addr"}, o_addr, m_addr);
    check({tag, "_oe_off"}, o_data_oe, 0);
    if (!BUSY_EN) check({tag, "_busy"}, o_busy, 0);
    else if (cyc + 3 < busy_end) check({tag, "_busy"}, o_busy, 1);
    else if (cyc > busy_end + 3) check({tag, "_busy"}, o_busy, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_oe", o_data_oe, 0);
    check("rst_data", o_data, 0);
    check("rst_wr_data", o_wr_data, 0);
    check("rst_wr_rs", o_wr_rs, 0);
    check("rst_wr_val", o_wr_val, 0);
    check("rst_rd_val", o_rd_val, 0);
    check("rst_busy", o_busy, 0);
    check("rst_addr", o_addr, 0);
    check("rst_viol", o_violation, 0);

    // Data write
    do_op("t2_dwr", 1'b1, 1'b0, 8'h41, 10, 1'b0);
    check("t2_addr1", o_addr, 7'h01);

    // Set DDRAM address, status while busy, then status when idle
    do_op("t3_set", 1'b0, 1'b0, 8'h8F, 10, 1'b0);
    do_op("t3_stat_busy", 1'b0, 1'b1, 8'h00, 4, 1'b0);
    check("t3_stat_busy_val", got_rdata, BUSY_EN ? 8'h8F : 8'h0F);
    do_op("t3_stat_idle", 1'b0, 1'b1, 8'h00, 6, 1'b0);
    check("t3_stat_idle_val", got_rdata, 8'h0F);

    // Clear, then a write inside the long busy window
    do_op("t4_clear", 1'b0, 1'b0, 8'h01, 10, 1'b0);
    do_op("t4_dwr_busy", 1'b1, 1'b0, 8'h55, 4, 1'b0);
    check("t4_viol", n_viol, BUSY_EN);
    check("t4_addr", o_addr, BUSY_EN ? 7'h00 : 7'h01);
    while (cyc < busy_end - 100) @(negedge clk);
    check("t4_busy_hold", o_busy, BUSY_EN);
    while (cyc <= busy_end + 5) @(negedge clk);
    check("t4_busy_clear", o_busy, 0);

    // Address wrap on a data read
    do_op("t5_set7f", 1'b0, 1'b0, 8'hFF, 10, 1'b0);
    i_rd_data = 8'hA5;
    do_op("t5_drd", 1'b1, 1'b1, 8'h00, 10, 1'b0);
    check("t5_rd_val", got_rdata, 8'hA5);
    check("t5_wrap", o_addr, 7'h00);

    // RS/RW toggled while EN high, and a one-cycle EN
    do_op("t6_tog_d", 1'b1, 1'b0, 8'h33, 10, 1'b1);
    check("t6_tog_d_rs", got_wrs, 1);
    do_op("t6_tog_i", 1'b0, 1'b0, 8'h85, 10, 1'b1);
    check("t6_tog_i_rs", got_wrs, 0);
    check("t6_tog_i_addr", o_addr, 7'h05);
    do_op("t6_glitch", 1'b1, 1'b0, 8'h66, 1, 1'b0);

    // Randomized accesses
    for (int it = 0; it < 30; it++) begin
      int         op;
      int         en;
      int         r;
      bit         tg;
      logic       rs, rw;
      logic [7:0] d;
      op = $urandom_range(0, 3);
      en = $urandom_range(1, 12);
      tg = (en >= 8) && ($urandom_range(0, 1) == 1);
      i_rd_data = 8'($urandom);
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) while (cyc <= busy_end + 10) @(negedge clk);
      case (op)
        0: begin rs = 1'b1; rw = 1'b0; end
        1: begin
          rs = 1'b0; rw = 1'b0;
          r = $urandom_range(0, 7);
          if (r == 0)     d = 8'($urandom_range(1, 3));
          else if (r < 4) d = 8'h80 | 8'($urandom_range(0, 127));
          else            d = 8'($urandom_range(4, 127));
        end
        2: begin rs = 1'b1; rw = 1'b1; end
        default: begin rs = 1'b0; rw = 1'b1; end
      endcase
      do_op($sformatf("rnd%0d", it), rs, rw, d, en, tg);
    end

    // Reset in the middle of a read
    while (cyc <= busy_end + 10) @(negedge clk);
    i_rs = 1'b1; i_rw = 1'b1;
    @(negedge clk);
    i_en = 1'b1;
    repeat (5) @(negedge clk);
    check("rr_oe_before", o_data_oe, 1);
    rst_n = 1'b0;
    #1;
    check("rr_oe_async", o_data_oe, 0);
    check("rr_addr", o_addr, 0);
    i_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_addr = 7'd0;
    busy_end = 0;
    do_op("rr_stat", 1'b0, 1'b1, 8'h00, 6, 1'b0);
    check("rr_stat_val", got_rdata, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
